// File: rtl/rs_pkg.sv
// Shared types for the reservation station: operand/tag/opcode widths, the
// entry record and the CDB tag-match helper.
package rs_pkg;

   localparam int RS_DATA_W = 8;
   localparam int RS_TAG_W  = 2;
   localparam int RS_OP_W   = 4;

   typedef logic [RS_DATA_W-1:0] data_t;
   typedef logic [RS_TAG_W-1:0]  tag_t;
   typedef logic [RS_OP_W-1:0]   op_t;

   localparam op_t OP_ADD = 4'b0000;
   localparam op_t OP_SUB = 4'b0001;
   localparam op_t OP_AND = 4'b0010;
   localparam op_t OP_OR  = 4'b0011;

   typedef struct packed {
      logic  busy;
      op_t   opcode;
      tag_t  rob_tag;
      logic  v1;
      data_t val1;
      tag_t  tag1;
      logic  v2;
      data_t val2;
      tag_t  tag2;
   } rs_entry_t;

   // An operand wakes when it is still pending and its producer is on the bus.
   function automatic logic tag_hit(input logic v, input tag_t t,
                                    input logic bus_valid, input tag_t bus_tag);
      return !v && bus_valid && (t == bus_tag);
   endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Older-than matrix: older[i][j]=1 means entry i was allocated before entry j.
// Produces a one-hot grant for the oldest eligible entry.
module rs_age_matrix #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     alloc_valid,
   input  logic [$clog2(DEPTH)-1:0] alloc_idx,
   input  logic                     free_valid,
   input  logic [$clog2(DEPTH)-1:0] free_idx,
   input  logic [DEPTH-1:0]         eligible,
   output logic [DEPTH-1:0]         oldest
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [DEPTH-1:0][DEPTH-1:0] older;
   logic [DEPTH-1:0][DEPTH-1:0] older_t;

   // A new entry is younger than everyone else; bits left behind in rows of
   // idle entries are harmless because an idle entry is never eligible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         older <= '0;
      end else if (clear) begin
         older <= '0;
      end else begin
         if (free_valid) begin
            for (int j = 0; j < DEPTH; j++) begin
               older[free_idx][j] <= 1'b0;
               older[j][free_idx] <= 1'b0;
            end
         end
         if (alloc_valid) begin
            for (int j = 0; j < DEPTH; j++) begin
               older[alloc_idx][j] <= 1'b0;
               older[j][alloc_idx] <= (IDX_W'(j) != alloc_idx);
            end
         end
      end
   end

   always_comb begin
      older_t = '0;
      oldest  = '0;
      for (int i = 0; i < DEPTH; i++)
         for (int j = 0; j < DEPTH; j++)
            older_t[i][j] = older[j][i];
      for (int i = 0; i < DEPTH; i++)
         oldest[i] = eligible[i] && !(|(eligible & older_t[i]));
   end

endmodule

// File: rtl/rs_dispatch.sv
// Reservation station: accepts renamed instructions, snoops the CDB for
// pending operands, dispatches the oldest ready entry through a holding register.
// Optional RS_WAKEUP_FWD_EN lets an entry woken by the current broadcast
// dispatch at the capture edge, taking the operand straight from the bus.
module rs_dispatch
   import rs_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = RS_DATA_W,
   parameter int TAG_W  = RS_TAG_W,
   parameter int OP_W   = RS_OP_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     issue_valid,
   output logic                     issue_ready,
   input  logic [OP_W-1:0]          issue_opcode,
   input  logic [TAG_W-1:0]         issue_rob_tag,
   input  logic                     issue_v1,
   input  logic                     issue_v2,
   input  logic [DATA_W-1:0]        issue_val1,
   input  logic [DATA_W-1:0]        issue_val2,
   input  logic [TAG_W-1:0]         issue_tag1,
   input  logic [TAG_W-1:0]         issue_tag2,
   input  logic                     cdb_valid,
   input  logic [TAG_W-1:0]         cdb_tag,
   input  logic [DATA_W-1:0]        cdb_value,
   output logic                     disp_valid,
   input  logic                     disp_ready,
   output logic [OP_W-1:0]          disp_opcode,
   output logic [DATA_W-1:0]        disp_op1,
   output logic [DATA_W-1:0]        disp_op2,
   output logic [TAG_W-1:0]         disp_rob_tag,
   output logic [$clog2(DEPTH):0]   free_count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   rs_entry_t [DEPTH-1:0] ent;
   rs_entry_t             new_ent;
   logic [DEPTH-1:0]      hit1, hit2, elig, grant;
   data_t [DEPTH-1:0]     rdy1, rdy2;
   logic [IDX_W-1:0]      alloc_idx, sel_idx;
   op_t                   sel_op;
   tag_t                  sel_tag;
   data_t                 sel_val1, sel_val2;
   logic                  issue_acc, disp_load;

   assign issue_ready = (free_count != '0);
   assign issue_acc   = issue_valid && issue_ready && !flush;
   assign disp_load   = !flush && (!disp_valid || disp_ready) && (|grant);

   always_comb begin
      alloc_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (!ent[i].busy) alloc_idx = IDX_W'(i);
   end

   // Same-cycle bypass: an operand produced on the bus this cycle is stored valid.
   always_comb begin
      new_ent         = '0;
      new_ent.busy    = 1'b1;
      new_ent.opcode  = issue_opcode;
      new_ent.rob_tag = issue_rob_tag;
      new_ent.v1      = issue_v1 || tag_hit(issue_v1, issue_tag1, cdb_valid, cdb_tag);
      new_ent.val1    = issue_v1 ? issue_val1 : cdb_value;
      new_ent.tag1    = issue_tag1;
      new_ent.v2      = issue_v2 || tag_hit(issue_v2, issue_tag2, cdb_valid, cdb_tag);
      new_ent.val2    = issue_v2 ? issue_val2 : cdb_value;
      new_ent.tag2    = issue_tag2;
   end

   always_comb begin
      hit1 = '0;
      hit2 = '0;
      elig = '0;
      rdy1 = '0;
      rdy2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit1[i] = ent[i].busy && tag_hit(ent[i].v1, ent[i].tag1, cdb_valid, cdb_tag);
         hit2[i] = ent[i].busy && tag_hit(ent[i].v2, ent[i].tag2, cdb_valid, cdb_tag);
`ifdef RS_WAKEUP_FWD_EN
         elig[i] = ent[i].busy && (ent[i].v1 || hit1[i]) && (ent[i].v2 || hit2[i]);
         rdy1[i] = hit1[i] ? cdb_value : ent[i].val1;
         rdy2[i] = hit2[i] ? cdb_value : ent[i].val2;
`else
         elig[i] = ent[i].busy && ent[i].v1 && ent[i].v2;
         rdy1[i] = ent[i].val1;
         rdy2[i] = ent[i].val2;
`endif
      end
   end

   always_comb begin
      sel_idx  = '0;
      sel_op   = '0;
      sel_tag  = '0;
      sel_val1 = '0;
      sel_val2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (grant[i]) begin
            sel_idx  = IDX_W'(i);
            sel_op   = ent[i].opcode;
            sel_tag  = ent[i].rob_tag;
            sel_val1 = rdy1[i];
            sel_val2 = rdy2[i];
         end
      end
   end

   rs_age_matrix #(.DEPTH(DEPTH)) u_age (
      .clk         (clk),
      .rst         (rst),
      .clear       (flush),
      .alloc_valid (issue_acc),
      .alloc_idx   (alloc_idx),
      .free_valid  (disp_load),
      .free_idx    (sel_idx),
      .eligible    (elig),
      .oldest      (grant)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent <= '0;
      end else if (flush) begin
         ent <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (hit1[i]) begin
               ent[i].v1   <= 1'b1;
               ent[i].val1 <= cdb_value;
            end
            if (hit2[i]) begin
               ent[i].v2   <= 1'b1;
               ent[i].val2 <= cdb_value;
            end
            if (disp_load && grant[i]) ent[i].busy <= 1'b0;
            if (issue_acc && (alloc_idx == IDX_W'(i))) ent[i] <= new_ent;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_valid   <= 1'b0;
         disp_opcode  <= '0;
         disp_op1     <= '0;
         disp_op2     <= '0;
         disp_rob_tag <= '0;
      end else if (flush) begin
         disp_valid <= 1'b0;
      end else if (disp_load) begin
         disp_valid   <= 1'b1;
         disp_opcode  <= sel_op;
         disp_op1     <= sel_val1;
         disp_op2     <= sel_val2;
         disp_rob_tag <= sel_tag;
      end else if (disp_ready) begin
         disp_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         free_count <= CNT_W'(DEPTH);
      else if (flush)
         free_count <= CNT_W'(DEPTH);
      else
         free_count <= free_count + CNT_W'(disp_load) - CNT_W'(issue_acc);
   end

endmodule

// File: tb/tb_rs_dispatch.sv
// Self-checking bench for rs_dispatch: table-driven single-issue vectors plus
// hand-written multi-cycle sequences, with a dispatch-order scoreboard.
module tb_rs_dispatch;
   import rs_pkg::*;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst, flush;
   logic       issue_valid, issue_ready;
   logic [3:0] issue_opcode;
   logic [1:0] issue_rob_tag, issue_tag1, issue_tag2;
   logic       issue_v1, issue_v2;
   logic [7:0] issue_val1, issue_val2;
   logic       cdb_valid;
   logic [1:0] cdb_tag;
   logic [7:0] cdb_value;
   logic       disp_valid, disp_ready;
   logic [3:0] disp_opcode;
   logic [7:0] disp_op1, disp_op2;
   logic [1:0] disp_rob_tag;
   logic [2:0] free_count;

   always #5 clk = ~clk;

   rs_dispatch #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_opcode(issue_opcode), .issue_rob_tag(issue_rob_tag),
      .issue_v1(issue_v1), .issue_v2(issue_v2),
      .issue_val1(issue_val1), .issue_val2(issue_val2),
      .issue_tag1(issue_tag1), .issue_tag2(issue_tag2),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_opcode(disp_opcode), .disp_op1(disp_op1), .disp_op2(disp_op2),
      .disp_rob_tag(disp_rob_tag), .free_count(free_count)
   );

   typedef struct {
      logic [3:0] op;
      logic [1:0] tag;
      logic [7:0] o1;
      logic [7:0] o2;
   } exp_t;

   typedef struct {
      logic [3:0] op;  logic [1:0] tag;
      logic v1; logic [7:0] val1; logic [1:0] t1;
      logic v2; logic [7:0] val2; logic [1:0] t2;
      logic cv; logic [1:0] ct; logic [7:0] cval;
      logic [7:0] e1; logic [7:0] e2;
   } vec_t;

   exp_t exp_q[$];
   vec_t tbl[5];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic drive_issue(input logic [3:0] op, input logic [1:0] tag,
                              input logic v1, input logic [7:0] val1, input logic [1:0] t1,
                              input logic v2, input logic [7:0] val2, input logic [1:0] t2);
      issue_valid = 1'b1; issue_opcode = op; issue_rob_tag = tag;
      issue_v1 = v1; issue_val1 = val1; issue_tag1 = t1;
      issue_v2 = v2; issue_val2 = val2; issue_tag2 = t2;
   endtask

   task automatic push(input logic [3:0] op, input logic [1:0] tag,
                       input logic [7:0] o1, input logic [7:0] o2);
      exp_t e;
      e.op = op; e.tag = tag; e.o1 = o1; e.o2 = o2;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      issue_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drain(input string name, input int max_cyc);
      int n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_drained"}, exp_q.size(), 0);
   endtask

   // Every accepted handshake must match the next expected dispatch in order.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && disp_valid && disp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_dispatch: got rob_tag %0d, expected none", disp_rob_tag);
         end else begin
            e = exp_q.pop_front();
            chk("sb_opcode", disp_opcode, e.op);
            chk("sb_op1", disp_op1, e.o1);
            chk("sb_op2", disp_op2, e.o2);
            chk("sb_rob_tag", disp_rob_tag, e.tag);
         end
      end
   end

   initial begin
      rst = 1'b1; disp_ready = 1'b0; cdb_tag = '0; cdb_value = '0;
      issue_opcode = '0; issue_rob_tag = '0; issue_v1 = 1'b0; issue_v2 = 1'b0;
      issue_val1 = '0; issue_val2 = '0; issue_tag1 = '0; issue_tag2 = '0;
      idle();

      //          op     tag   v1    val1   t1    v2    val2   t2    cv    ct    cval   e1     e2
      tbl[0] = '{OP_SUB, 2'd2, 1'b1, 8'h05, 2'd0, 1'b1, 8'h03, 2'd0, 1'b0, 2'd0, 8'h00, 8'h05, 8'h03};
      tbl[1] = '{OP_AND, 2'd1, 1'b0, 8'h00, 2'd0, 1'b1, 8'h22, 2'd0, 1'b1, 2'd0, 8'h11, 8'h11, 8'h22};
      tbl[2] = '{OP_OR,  2'd3, 1'b0, 8'h00, 2'd3, 1'b0, 8'h00, 2'd3, 1'b1, 2'd3, 8'h5A, 8'h5A, 8'h5A};
      tbl[3] = '{OP_ADD, 2'd0, 1'b1, 8'hFF, 2'd1, 1'b1, 8'h00, 2'd1, 1'b1, 2'd1, 8'h77, 8'hFF, 8'h00};
      tbl[4] = '{OP_SUB, 2'd3, 1'b1, 8'h7F, 2'd0, 1'b0, 8'h00, 2'd1, 1'b1, 2'd1, 8'h80, 8'h7F, 8'h80};

      #12;
      chk("rst_disp_valid", disp_valid, 0);
      chk("rst_free_count", free_count, 4);
      chk("rst_issue_ready", issue_ready, 1);
      chk("rst_disp_op1", disp_op1, 0);
      chk("rst_disp_rob_tag", disp_rob_tag, 0);
      rst = 1'b0;
      step();

      // Single issues: ready, bypassed, both-from-bus, valid-not-overwritten.
      disp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         drive_issue(tbl[k].op, tbl[k].tag, tbl[k].v1, tbl[k].val1, tbl[k].t1,
                     tbl[k].v2, tbl[k].val2, tbl[k].t2);
         cdb_valid = tbl[k].cv; cdb_tag = tbl[k].ct; cdb_value = tbl[k].cval;
         push(tbl[k].op, tbl[k].tag, tbl[k].e1, tbl[k].e2);
         step();
         idle();
         @(negedge clk);
         chk("vec_fc_alloc", free_count, 3);
         chk("vec_dv_lat0", disp_valid, 0);
         @(negedge clk);
         chk("vec_dv_lat1", disp_valid, 1);
         chk("vec_fc_load", free_count, 4);
         @(negedge clk);
         chk("vec_dv_fall", disp_valid, 0);
      end
      step();

      // CDB wake-up of a pending operand, with a non-matching broadcast first.
      drive_issue(OP_SUB, 2'd1, 1'b0, 8'h00, 2'd3, 1'b1, 8'h44, 2'd0);
      push(OP_SUB, 2'd1, 8'hAA, 8'h44);
      step();
      idle();
      cdb_valid = 1'b1; cdb_tag = 2'd2; cdb_value = 8'h99;
      step();
      cdb_tag = 2'd3; cdb_value = 8'hAA;
      @(negedge clk);
      chk("wake_before", disp_valid, 0);
      step();
      idle();
      @(negedge clk);
`ifdef RS_WAKEUP_FWD_EN
      chk("wake_edge", disp_valid, 1);
      @(negedge clk);
      chk("wake_after", disp_valid, 0);
`else
      chk("wake_edge", disp_valid, 0);
      @(negedge clk);
      chk("wake_after", disp_valid, 1);
`endif
      drain("wake", 10);
      step();

      // Fill: one instruction held in the dispatch register plus four entries.
      disp_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive_issue(4'(k % 4), 2'(k % 4), 1'b1, 8'h10 + 8'(k), 2'd0, 1'b1, 8'h20 + 8'(k), 2'd0);
         push(4'(k % 4), 2'(k % 4), 8'h10 + 8'(k), 8'h20 + 8'(k));
         step();
      end
      idle();
      chk("full_issue_ready", issue_ready, 0);
      chk("full_fc", free_count, 0);
      chk("full_dv", disp_valid, 1);
      drive_issue(OP_OR, 2'd0, 1'b1, 8'hEE, 2'd0, 1'b1, 8'hEE, 2'd0);
      step();
      idle();
      chk("full_ignored_fc", free_count, 0);
      drive_issue(OP_AND, 2'd1, 1'b1, 8'h3C, 2'd0, 1'b1, 8'h4D, 2'd0);
      push(OP_AND, 2'd1, 8'h3C, 8'h4D);
      disp_ready = 1'b1;
      step();
      chk("first_free_fc", free_count, 1);
      chk("first_free_ready", issue_ready, 1);
      step();
      idle();
      chk("reissue_fc", free_count, 1);
      drain("fill", 20);
      step();
      step();
      chk("fill_fc_final", free_count, 4);

      // Younger ready entry bypasses an older pending one.
      drive_issue(OP_ADD, 2'd2, 1'b0, 8'h00, 2'd1, 1'b1, 8'h66, 2'd0);
      step();
      drive_issue(OP_SUB, 2'd3, 1'b1, 8'h77, 2'd0, 1'b1, 8'h88, 2'd0);
      push(OP_SUB, 2'd3, 8'h77, 8'h88);
      push(OP_ADD, 2'd2, 8'h55, 8'h66);
      step();
      idle();
      step();
      cdb_valid = 1'b1; cdb_tag = 2'd1; cdb_value = 8'h55;
      step();
      idle();
      drain("age_a", 10);
      step();

      // Two entries ready together: the older one wins over the lower index.
      disp_ready = 1'b0;
      drive_issue(OP_AND, 2'd0, 1'b1, 8'h01, 2'd0, 1'b1, 8'h02, 2'd0);
      push(OP_AND, 2'd0, 8'h01, 8'h02);
      step();
      drive_issue(OP_OR, 2'd1, 1'b0, 8'h00, 2'd0, 1'b1, 8'h0B, 2'd0);
      push(OP_OR, 2'd1, 8'h0A, 8'h0B);
      step();
      drive_issue(OP_ADD, 2'd2, 1'b1, 8'h0C, 2'd0, 1'b1, 8'h0D, 2'd0);
      push(OP_ADD, 2'd2, 8'h0C, 8'h0D);
      step();
      idle();
      cdb_valid = 1'b1; cdb_tag = 2'd0; cdb_value = 8'h0A;
      step();
      idle();
      disp_ready = 1'b1;
      drain("age_b", 10);
      step();

      // Flush with three busy entries and a held dispatch; same-cycle issue dropped.
      disp_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive_issue(OP_ADD, 2'(k), 1'b1, 8'(k), 2'd0, 1'b1, 8'(k), 2'd0);
         step();
      end
      idle();
      chk("flush_pre_fc", free_count, 1);
      chk("flush_pre_dv", disp_valid, 1);
      drive_issue(OP_SUB, 2'd0, 1'b1, 8'hC0, 2'd0, 1'b1, 8'hC1, 2'd0);
      cdb_valid = 1'b1; cdb_tag = 2'd3; cdb_value = 8'hDD;
      flush = 1'b1;
      step();
      idle();
      chk("flush_dv", disp_valid, 0);
      chk("flush_fc", free_count, 4);
      chk("flush_issue_ready", issue_ready, 1);
      disp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("flush_quiet_dv", disp_valid, 0);
      end
      drive_issue(OP_ADD, 2'd3, 1'b1, 8'h12, 2'd0, 1'b1, 8'h34, 2'd0);
      push(OP_ADD, 2'd3, 8'h12, 8'h34);
      step();
      idle();
      drain("post_flush", 10);
      step();

      // Asynchronous reset in mid-cycle discards everything at once.
      disp_ready = 1'b0;
      drive_issue(OP_OR, 2'd1, 1'b1, 8'h5C, 2'd0, 1'b1, 8'h6D, 2'd0);
      step();
      drive_issue(OP_OR, 2'd2, 1'b1, 8'h7E, 2'd0, 1'b1, 8'h8F, 2'd0);
      step();
      idle();
      chk("mid_pre_dv", disp_valid, 1);
      #3 rst = 1'b1;
      #1;
      chk("mid_rst_dv", disp_valid, 0);
      chk("mid_rst_fc", free_count, 4);
      chk("mid_rst_op1", disp_op1, 0);
      #1 rst = 1'b0;
      disp_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         chk("mid_rst_quiet_dv", disp_valid, 0);
      end

      chk("final_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
